// File: rtl/bp_be_cache_req_arbiter.sv
// Two-requester round-robin arbiter for the BE-to-LCE cache-request channel.
// Ownership is held from request acceptance through metadata until completion.
module bp_be_cache_req_arbiter #(
    parameter int cache_req_width_p          = 64,
    parameter int cache_req_metadata_width_p = 8
) (
    input  logic                                    clk_i,
    input  logic                                    reset_i,
    input  logic [2*cache_req_width_p-1:0]          req_i,
    input  logic [1:0]                              req_v_i,
    output logic [1:0]                              req_ready_o,
    input  logic [2*cache_req_metadata_width_p-1:0] req_metadata_i,
    input  logic [1:0]                              req_metadata_v_i,
    output logic [1:0]                              req_complete_o,
    output logic [cache_req_width_p-1:0]            cache_req_o,
    output logic                                    cache_req_v_o,
    input  logic                                    cache_req_ready_i,
    output logic [cache_req_metadata_width_p-1:0]   cache_req_metadata_o,
    output logic                                    cache_req_metadata_v_o,
    input  logic                                    cache_req_complete_i,
    output logic                                    owner_o,
    output logic                                    busy_o,
    output logic                                    proto_err_o
);

    localparam int W = cache_req_width_p;
    localparam int M = cache_req_metadata_width_p;

    typedef enum logic [1:0] {
        e_idle,
        e_wait_meta,
        e_wait_complete
    } state_e;

    state_e state_q, state_d;
    logic   last_grant_q, last_grant_d;
    logic   owner_q, owner_d;
    logic   proto_err_q, proto_err_d;
    logic   grant;
    logic   xfer;

    // Grant never looks at LCE ready, so valid/data are stable under backpressure
    always_comb begin
        if (&req_v_i) begin
            grant = ~last_grant_q;
        end else begin
            grant = req_v_i[1];
        end
    end

    assign xfer = (state_q == e_idle) & (|req_v_i) & cache_req_ready_i;

    always_comb begin
        cache_req_v_o          = 1'b0;
        cache_req_o            = '0;
        req_ready_o            = 2'b00;
        cache_req_metadata_v_o = 1'b0;
        cache_req_metadata_o   = '0;
        req_complete_o         = 2'b00;
        unique case (state_q)
            e_idle: begin
                cache_req_v_o      = |req_v_i;
                cache_req_o        = grant ? req_i[2*W-1:W] : req_i[W-1:0];
                req_ready_o[grant] = cache_req_ready_i;
            end
            e_wait_meta: begin
                cache_req_metadata_v_o = req_metadata_v_i[owner_q];
                cache_req_metadata_o   = owner_q ? req_metadata_i[2*M-1:M]
                                                 : req_metadata_i[M-1:0];
                req_complete_o[owner_q] = cache_req_complete_i;
            end
            e_wait_complete: begin
                req_complete_o[owner_q] = cache_req_complete_i;
            end
            default: begin
                cache_req_v_o = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        proto_err_d  = proto_err_q;
        unique case (state_q)
            e_idle: begin
                if (cache_req_complete_i) begin
                    proto_err_d = 1'b1;
                end
                if (xfer) begin
                    owner_d      = grant;
                    last_grant_d = grant;
                    state_d      = e_wait_meta;
                end
            end
            e_wait_meta: begin
                // An early completion means the LCE is done; metadata is dropped
                if (cache_req_complete_i) begin
                    proto_err_d = 1'b1;
                    state_d     = e_idle;
                end else if (req_metadata_v_i[owner_q]) begin
                    state_d = e_wait_complete;
                end
            end
            e_wait_complete: begin
                if (cache_req_complete_i) begin
                    state_d = e_idle;
                end
            end
            default: begin
                state_d = e_idle;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= e_idle;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            proto_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            proto_err_q  <= proto_err_d;
        end
    end

    assign owner_o     = owner_q;
    assign busy_o      = (state_q != e_idle);
    assign proto_err_o = proto_err_q;

endmodule
